// File: rtl/sram22_req_adapter.sv
// sram22_req_adapter
// Bridges a valid/ready request channel onto a single-port SRAM22 macro and
// returns read data through a 2-entry response FIFO. The macro's dout is only
// valid in the cycle right after a read, so it is captured then and held in
// the FIFO until the consumer takes it.
// Optional feature: define SRAM22_WR_RESP_EN to return an acknowledge entry
// (resp_wr=1, resp_data=0) for every write, ordered with read responses.
module sram22_req_adapter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_din,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_WIDTH-1:0]  resp_data,
    output logic                   resp_wr,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    logic                  fire;
    logic                  pop;
    logic                  push;
    logic                  push_wr;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pend;
    logic                  pend_wr;
    logic [1:0]            occ;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [2:0]            need;
    logic [DATA_WIDTH-1:0] fifo_data [2];

    assign fire = req_valid && req_ready;
    assign pop  = resp_valid && resp_ready;

`ifdef SRAM22_WR_RESP_EN
    // Every accepted request, read or write, lands in the FIFO one edge later.
    assign push      = pend;
    assign push_wr   = pend_wr;
    assign push_data = pend_wr ? '0 : sram_dout;
`else
    // Only reads produce a response; a pending write holds no FIFO slot.
    assign push      = pend && !pend_wr;
    assign push_wr   = 1'b0;
    assign push_data = sram_dout;
`endif

    // Occupancy after the next edge if one more request were accepted now must
    // leave room for that request's own push, so the FIFO can never overflow.
    assign need      = {1'b0, occ} + {2'b00, push} - {2'b00, pop};
    assign req_ready = (need <= 3'd1);

    // The macro sees the request directly; writes are suppressed during reset.
    assign sram_we    = fire && req_we && !rst;
    assign sram_wmask = sram_we ? req_wmask : '0;
    assign sram_addr  = req_addr;
    assign sram_din   = req_din;

    assign resp_valid = (occ != 2'd0);
    assign resp_data  = fifo_data[rd_ptr];

    // Remember what was accepted this edge so its response is captured next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            pend_wr <= 1'b0;
        end else begin
            pend    <= fire;
            pend_wr <= fire && req_we;
        end
    end

    // Response FIFO storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ          <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef SRAM22_WR_RESP_EN
    logic fifo_wr [2];

    // Per-entry write-ack flag travelling alongside the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr[0] <= 1'b0;
            fifo_wr[1] <= 1'b0;
        end else if (push) begin
            fifo_wr[wr_ptr] <= push_wr;
        end
    end

    assign resp_wr = fifo_wr[rd_ptr];
`else
    assign resp_wr = push_wr;
`endif

endmodule

// File: tb/tb_sram22_req_adapter.sv
// tb_sram22_req_adapter
// Directed bench for sram22_req_adapter with a behavioural SRAM22 macro model.
// Build with SRAM22_WR_RESP_EN defined to exercise write acknowledges.
module tb_sram22_req_adapter;

    localparam int DW   = 32;
    localparam int AW   = 6;
    localparam int MW   = 1;
    localparam int LANE = DW / MW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [MW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_din;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_wr;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    logic [DW-1:0] mem [64];

    int total = 0;
    int bad   = 0;
    int n_obs;
    logic [DW-1:0] obs_data [8];
    logic          obs_wr   [8];
    int            obs_cyc  [8];

    sram22_req_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_din    (req_din),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_wr    (resp_wr),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    always #5 clk = ~clk;

    // SRAM22 macro model: masked write on we, otherwise dout reloads from addr.
    always @(posedge clk) begin
        if (sram_we) begin
            for (int l = 0; l < MW; l++) begin
                if (sram_wmask[l]) mem[sram_addr][l*LANE +: LANE] <= sram_din[l*LANE +: LANE];
            end
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [MW-1:0] m,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_we    = we;
        req_wmask = m;
        req_addr  = a;
        req_din   = d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write then read one address with resp_ready high, logging every response
    // together with the cycle (relative to read acceptance) it was seen in.
    task automatic writeThenRead(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        resp_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, m, a, d);
        tick();
        applyStimulus(1'b1, 1'b0, '0, a, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        n_obs = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid && n_obs < 8) begin
                obs_data[n_obs] = resp_data;
                obs_wr[n_obs]   = resp_wr;
                obs_cyc[n_obs]  = c;
                n_obs++;
            end
            tick();
        end
    endtask

    initial begin
        int exp_idx;
        rst        = 1'b1;
        resp_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);

        // Reset state
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_data", resp_data, 0);
        checkOutput("rst_resp_wr", resp_wr, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_req_ready", req_ready, 1);

        // Preload mem[i]=i through the adapter, checking macro-port passthrough
        resp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, AW'(i), DW'(i));
            checkOutput("pre_ready", req_ready, 1);
            if (i < 3) begin
                checkOutput("pre_sram_we", sram_we, 1);
                checkOutput("pre_sram_wmask", sram_wmask, 1);
                checkOutput("pre_sram_addr", sram_addr, i);
                checkOutput("pre_sram_din", sram_din, i);
            end
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        checkOutput("pre_drained", resp_valid, 0);

        // Streaming reads 0..63, one accept per cycle, data in order
        exp_idx = 0;
        for (int i = 0; i < 70; i++) begin
            if (i < 64) applyStimulus(1'b1, 1'b0, 1'b1, AW'(i), '0);
            else        applyStimulus(1'b0, 1'b0, '0, '0, '0);
            if (i < 64) begin
                checkOutput("stream_ready", req_ready, 1);
                checkOutput("stream_sram_we", sram_we, 0);
                checkOutput("stream_sram_wmask", sram_wmask, 0);
            end
            if (resp_valid) begin
                checkOutput("stream_data", resp_data, exp_idx);
                checkOutput("stream_wr", resp_wr, 0);
                exp_idx++;
            end
            if (i == 2) checkOutput("stream_first_latency", exp_idx, 1);
            tick();
        end
        checkOutput("stream_count", exp_idx, 64);

        // Back-pressure: three reads with resp_ready low
        resp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 6'd10, '0);
        checkOutput("bp_ready1", req_ready, 1);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 6'd11, '0);
        checkOutput("bp_ready2", req_ready, 1);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 6'd12, '0);
        checkOutput("bp_ready3_blocked", req_ready, 0);
        tick();
        checkOutput("bp_still_blocked", req_ready, 0);
        checkOutput("bp_head1", resp_data, 10);
        tick();
        checkOutput("bp_full_blocked", req_ready, 0);
        checkOutput("bp_head1_held", resp_data, 10);
        resp_ready = 1'b1;
        #1;
        checkOutput("bp_ready_on_pop", req_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("bp_head2", resp_data, 11);
        tick();
        checkOutput("bp_head3", resp_data, 12);
        checkOutput("bp_head3_valid", resp_valid, 1);
        tick();
        checkOutput("bp_empty", resp_valid, 0);

        // Held response survives idle cycles that clobber sram_dout
        resp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 6'd20, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 6'd30, '0);
        tick();
        checkOutput("hold_data0", resp_data, 20);
        applyStimulus(1'b0, 1'b0, '0, 6'd31, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 6'd32, '0);
        tick();
        checkOutput("hold_dout_moved", sram_dout, 32);
        checkOutput("hold_data3", resp_data, 20);
        checkOutput("hold_valid", resp_valid, 1);
        resp_ready = 1'b1;
        tick();
        checkOutput("hold_popped", resp_valid, 0);

        // Write 0xDEADBEEF to addr 5 then read it back
        writeThenRead(6'd5, 32'hDEADBEEF, 1'b1);
`ifdef SRAM22_WR_RESP_EN
        checkOutput("wr5_count", n_obs, 2);
        checkOutput("wr5_ack_wr", obs_wr[0], 1);
        checkOutput("wr5_ack_data", obs_data[0], 0);
        checkOutput("wr5_ack_cyc", obs_cyc[0], 0);
        checkOutput("wr5_rd_wr", obs_wr[1], 0);
        checkOutput("wr5_rd_data", obs_data[1], 32'hDEADBEEF);
        checkOutput("wr5_rd_cyc", obs_cyc[1], 1);
`else
        checkOutput("wr5_count", n_obs, 1);
        checkOutput("wr5_rd_wr", obs_wr[0], 0);
        checkOutput("wr5_rd_data", obs_data[0], 32'hDEADBEEF);
        checkOutput("wr5_rd_cyc", obs_cyc[0], 1);
`endif

        // Write then read addr 7
        writeThenRead(6'd7, 32'h1234_5678, 1'b1);
`ifdef SRAM22_WR_RESP_EN
        checkOutput("wr7_count", n_obs, 2);
        checkOutput("wr7_ack_wr", obs_wr[0], 1);
        checkOutput("wr7_ack_data", obs_data[0], 0);
        checkOutput("wr7_rd_wr", obs_wr[1], 0);
        checkOutput("wr7_rd_data", obs_data[1], 32'h1234_5678);
`else
        checkOutput("wr7_count", n_obs, 1);
        checkOutput("wr7_rd_data", obs_data[0], 32'h1234_5678);
`endif

        // Masked-off write leaves memory untouched
        writeThenRead(6'd8, 32'hFFFF_FFFF, 1'b0);
`ifdef SRAM22_WR_RESP_EN
        checkOutput("wm0_count", n_obs, 2);
        checkOutput("wm0_rd_data", obs_data[1], 8);
`else
        checkOutput("wm0_count", n_obs, 1);
        checkOutput("wm0_rd_data", obs_data[0], 8);
`endif

        // Reset one cycle after a read is accepted drops it
        resp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 6'd3, '0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd4, 32'hA5A5_A5A5);
        checkOutput("rrst_sram_we", sram_we, 0);
        checkOutput("rrst_sram_wmask", sram_wmask, 0);
        checkOutput("rrst_resp_valid", resp_valid, 0);
        tick();
        checkOutput("rrst_sram_we2", sram_we, 0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("rrst_req_ready", req_ready, 1);
        tick();
        tick();
        checkOutput("rrst_no_resp", resp_valid, 0);
        checkOutput("rrst_occ", dut.occ, 0);
        // Write during reset must not have reached memory
        applyStimulus(1'b1, 1'b0, '0, 6'd4, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("rrst_mem_intact", resp_data, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
